// File: rtl/decode_stage.sv
// RV32I decode stage: field extraction, immediate generation, 32x32 register
// file with same-cycle write-back bypass, and a stall-holdable ALU output set.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        I_instr_valid,
  input  logic [31:0] I_instr,
  input  logic        I_stall,
  input  logic        I_wb_en,
  input  logic [4:0]  I_wb_rd,
  input  logic [31:0] I_wb_data,
  output logic        O_ready,
  output logic        O_en,
  output logic [6:0]  O_op,
  output logic [2:0]  O_funct3,
  output logic [6:0]  O_funct7,
  output logic [31:0] O_dataA,
  output logic [31:0] O_dataB,
  output logic [31:0] O_imm,
  output logic [4:0]  O_rd,
  output logic        O_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [31:0] regs_r [32];
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [31:0] rs1_val_s;
  logic [31:0] rs2_val_s;
  logic [31:0] imm_s;
  logic        legal_s;

  // x0 is hardwired to zero; a same-cycle write-back to the source wins over the file
  function automatic logic [31:0] read_operand(
    input logic [4:0]  idx,
    input logic [31:0] rf_val,
    input logic        wb_en,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_data
  );
    logic [31:0] val;
    if (idx == 5'd0) begin
      val = 32'd0;
    end else if (wb_en && (wb_rd == idx)) begin
      val = wb_data;
    end else begin
      val = rf_val;
    end
    return val;
  endfunction

  assign O_ready = !I_stall && !rst;
  assign rs1_s   = I_instr[19:15];
  assign rs2_s   = I_instr[24:20];

  // operand fetch with write-back bypass
  always_comb begin
    rs1_val_s = read_operand(rs1_s, regs_r[rs1_s], I_wb_en, I_wb_rd, I_wb_data);
    rs2_val_s = read_operand(rs2_s, regs_r[rs2_s], I_wb_en, I_wb_rd, I_wb_data);
  end

  // opcode legality and immediate format selection
  always_comb begin
    legal_s = 1'b0;
    imm_s   = 32'd0;
    case (I_instr[6:0])
      OP_R: begin
        legal_s = 1'b1;
        imm_s   = 32'd0;
      end
      OP_I_ALU, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        legal_s = 1'b1;
        imm_s   = {{20{I_instr[31]}}, I_instr[31:20]};
      end
      OP_STORE: begin
        legal_s = 1'b1;
        imm_s   = {{20{I_instr[31]}}, I_instr[31:25], I_instr[11:7]};
      end
      OP_BRANCH: begin
        legal_s = 1'b1;
        imm_s   = {{19{I_instr[31]}}, I_instr[31], I_instr[7], I_instr[30:25], I_instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        legal_s = 1'b1;
        imm_s   = {I_instr[31:12], 12'd0};
      end
      OP_JAL: begin
        legal_s = 1'b1;
        imm_s   = {{11{I_instr[31]}}, I_instr[31], I_instr[19:12], I_instr[20], I_instr[30:21], 1'b0};
      end
      default: begin
        legal_s = 1'b0;
        imm_s   = 32'd0;
      end
    endcase
  end

  // register file: cleared by reset, written regardless of stall
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (I_wb_en && (I_wb_rd != 5'd0)) begin
      regs_r[I_wb_rd] <= I_wb_data;
    end
  end

  // ALU-facing output registers: capture when not stalled, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      O_en      <= 1'b0;
      O_illegal <= 1'b0;
      O_op      <= 7'd0;
      O_funct3  <= 3'd0;
      O_funct7  <= 7'd0;
      O_dataA   <= 32'd0;
      O_dataB   <= 32'd0;
      O_imm     <= 32'd0;
      O_rd      <= 5'd0;
    end else if (!I_stall) begin
      O_en      <= I_instr_valid && legal_s;
      O_illegal <= I_instr_valid && !legal_s;
      O_op      <= I_instr[6:0];
      O_funct3  <= I_instr[14:12];
      O_funct7  <= I_instr[31:25];
      O_dataA   <= rs1_val_s;
      O_dataB   <= rs2_val_s;
      O_imm     <= imm_s;
      O_rd      <= I_instr[11:7];
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, then randomized traffic
// checked against a behavioural model of the register file and decoder.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        I_instr_valid;
  logic [31:0] I_instr;
  logic        I_stall;
  logic        I_wb_en;
  logic [4:0]  I_wb_rd;
  logic [31:0] I_wb_data;
  logic        O_ready;
  logic        O_en;
  logic [6:0]  O_op;
  logic [2:0]  O_funct3;
  logic [6:0]  O_funct7;
  logic [31:0] O_dataA;
  logic [31:0] O_dataB;
  logic [31:0] O_imm;
  logic [4:0]  O_rd;
  logic        O_illegal;

  decode_stage dut (
    .clk(clk), .rst(rst), .I_instr_valid(I_instr_valid), .I_instr(I_instr),
    .I_stall(I_stall), .I_wb_en(I_wb_en), .I_wb_rd(I_wb_rd), .I_wb_data(I_wb_data),
    .O_ready(O_ready), .O_en(O_en), .O_op(O_op), .O_funct3(O_funct3),
    .O_funct7(O_funct7), .O_dataA(O_dataA), .O_dataB(O_dataB), .O_imm(O_imm),
    .O_rd(O_rd), .O_illegal(O_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        ill;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] a;
    logic [31:0] b;
  } out_t;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        vld;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    out_t        exp;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];
  logic [31:0] m_regs [32];
  out_t m_out;

  function automatic vec_t mk(
    input logic r, input logic st, input logic v, input logic [31:0] ins,
    input logic we, input logic [4:0] wrd, input logic [31:0] wd,
    input logic en, input logic ill, input logic [6:0] op, input logic [2:0] f3,
    input logic [6:0] f7, input logic [4:0] rd, input logic [31:0] imm,
    input logic [31:0] a, input logic [31:0] b);
    vec_t t;
    t.rst = r; t.stall = st; t.vld = v; t.instr = ins;
    t.wb_en = we; t.wb_rd = wrd; t.wb_data = wd;
    t.exp.en = en; t.exp.ill = ill; t.exp.op = op; t.exp.f3 = f3; t.exp.f7 = f7;
    t.exp.rd = rd; t.exp.imm = imm; t.exp.a = a; t.exp.b = b;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @vec %0d: got 0x%08h, expected 0x%08h", name, n_vec, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst = t.rst; I_stall = t.stall; I_instr_valid = t.vld; I_instr = t.instr;
    I_wb_en = t.wb_en; I_wb_rd = t.wb_rd; I_wb_data = t.wb_data;
  endtask

  // drive at negedge, check ready combinationally, then outputs just after posedge
  task automatic apply(input vec_t t, input out_t exp);
    @(negedge clk);
    drive(t);
    #1;
    check("ready", {31'd0, O_ready}, {31'd0, !t.stall && !t.rst});
    @(posedge clk);
    #1;
    n_vec++;
    check("en",     {31'd0, O_en},      {31'd0, exp.en});
    check("illegal",{31'd0, O_illegal}, {31'd0, exp.ill});
    check("op",     {25'd0, O_op},      {25'd0, exp.op});
    check("funct3", {29'd0, O_funct3},  {29'd0, exp.f3});
    check("funct7", {25'd0, O_funct7},  {25'd0, exp.f7});
    check("rd",     {27'd0, O_rd},      {27'd0, exp.rd});
    check("imm",    O_imm,   exp.imm);
    check("dataA",  O_dataA, exp.a);
    check("dataB",  O_dataB, exp.b);
  endtask

  // immediate assembled from the format rules with shifts and masks
  function automatic logic [31:0] ref_imm(input logic [31:0] ins, input string kind);
    logic [31:0] top;
    top = ins[31] ? 32'hFFFF_FFFF : 32'h0000_0000;
    case (kind)
      "I": return (top << 12) | (ins >> 20);
      "S": return (top << 12) | ((ins >> 25) << 5) | ((ins >> 7) & 32'h1F);
      "B": return (top << 12) | (((ins >> 7) & 32'h1) << 11) | (((ins >> 25) & 32'h3F) << 5)
                  | (((ins >> 8) & 32'hF) << 1);
      "U": return ins & 32'hFFFF_F000;
      "J": return (top << 20) | (((ins >> 12) & 32'hFF) << 12) | (((ins >> 20) & 32'h1) << 11)
                  | (((ins >> 21) & 32'h3FF) << 1);
      default: return 32'd0;
    endcase
  endfunction

  function automatic string ref_kind(input logic [6:0] op);
    case (op)
      7'b0110011: return "R";
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: return "I";
      7'b0100011: return "S";
      7'b1100011: return "B";
      7'b0110111, 7'b0010111: return "U";
      7'b1101111: return "J";
      default: return "X";
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx, input vec_t t);
    if (idx == 5'd0) return 32'd0;
    if (t.wb_en && t.wb_rd == idx) return t.wb_data;
    return m_regs[idx];
  endfunction

  task automatic model_step(input vec_t t);
    string k;
    if (t.rst) begin
      m_out = '{default: '0};
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    end else begin
      if (!t.stall) begin
        k = ref_kind(t.instr[6:0]);
        m_out.en  = t.vld && (k != "X");
        m_out.ill = t.vld && (k == "X");
        m_out.op  = t.instr[6:0];
        m_out.f3  = t.instr[14:12];
        m_out.f7  = t.instr[31:25];
        m_out.rd  = t.instr[11:7];
        m_out.imm = ref_imm(t.instr, k);
        m_out.a   = ref_read(t.instr[19:15], t);
        m_out.b   = ref_read(t.instr[24:20], t);
      end
      if (t.wb_en && t.wb_rd != 5'd0) m_regs[t.wb_rd] = t.wb_data;
    end
  endtask

  initial begin
    logic [6:0] legal_ops [10];
    vec_t t;
    logic [31:0] r;

    legal_ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73};
    rst = 1'b1; I_stall = 1'b0; I_instr_valid = 1'b0; I_instr = 32'd0;
    I_wb_en = 1'b0; I_wb_rd = 5'd0; I_wb_data = 32'd0;

    //           rst st v  instr         we rd     wdata     en ill op     f3    f7     rd     imm            A      B
    tbl.push_back(mk(1, 0, 1, 32'h003010B3, 0, 5'd0,  32'h0,  0, 0, 7'h00, 3'd0, 7'h00, 5'd0, 32'h0,         32'd0, 32'd0));
    tbl.push_back(mk(0, 0, 1, 32'h003010B3, 0, 5'd0,  32'h0,  1, 0, 7'h33, 3'd1, 7'h00, 5'd1, 32'h0,         32'd0, 32'd0));
    tbl.push_back(mk(0, 0, 0, 32'h00000000, 1, 5'd3,  32'd3,  0, 0, 7'h00, 3'd0, 7'h00, 5'd0, 32'h0,         32'd0, 32'd0));
    tbl.push_back(mk(0, 0, 1, 32'h003010B3, 0, 5'd0,  32'h0,  1, 0, 7'h33, 3'd1, 7'h00, 5'd1, 32'h0,         32'd0, 32'd3));
    tbl.push_back(mk(0, 0, 1, 32'h00948163, 1, 5'd9,  32'd9,  1, 0, 7'h63, 3'd0, 7'h00, 5'd2, 32'h2,         32'd9, 32'd9));
    tbl.push_back(mk(0, 0, 1, 32'h0BA08113, 0, 5'd0,  32'h0,  1, 0, 7'h13, 3'd0, 7'h05, 5'd2, 32'hBA,        32'd0, 32'd0));
    tbl.push_back(mk(0, 1, 1, 32'hFFF00093, 1, 5'd26, 32'd7,  1, 0, 7'h13, 3'd0, 7'h05, 5'd2, 32'hBA,        32'd0, 32'd0));
    tbl.push_back(mk(0, 1, 1, 32'hFFF00093, 0, 5'd0,  32'h0,  1, 0, 7'h13, 3'd0, 7'h05, 5'd2, 32'hBA,        32'd0, 32'd0));
    tbl.push_back(mk(0, 1, 1, 32'hFFF00093, 0, 5'd0,  32'h0,  1, 0, 7'h13, 3'd0, 7'h05, 5'd2, 32'hBA,        32'd0, 32'd0));
    tbl.push_back(mk(0, 0, 1, 32'hFFF00093, 0, 5'd0,  32'h0,  1, 0, 7'h13, 3'd0, 7'h7F, 5'd1, 32'hFFFFFFFF,  32'd0, 32'd0));
    tbl.push_back(mk(0, 0, 1, 32'h0000007F, 0, 5'd0,  32'h0,  0, 1, 7'h7F, 3'd0, 7'h00, 5'd0, 32'h0,         32'd0, 32'd0));
    tbl.push_back(mk(0, 0, 0, 32'h00000000, 1, 5'd0,  32'h55, 0, 0, 7'h00, 3'd0, 7'h00, 5'd0, 32'h0,         32'd0, 32'd0));
    tbl.push_back(mk(0, 0, 1, 32'h00000033, 1, 5'd0,  32'h55, 1, 0, 7'h33, 3'd0, 7'h00, 5'd0, 32'h0,         32'd0, 32'd0));
    tbl.push_back(mk(0, 0, 1, 32'h01A00033, 0, 5'd0,  32'h0,  1, 0, 7'h33, 3'd0, 7'h00, 5'd0, 32'h0,         32'd0, 32'd7));
    tbl.push_back(mk(1, 1, 1, 32'h0BA08113, 1, 5'd3,  32'h77, 0, 0, 7'h00, 3'd0, 7'h00, 5'd0, 32'h0,         32'd0, 32'd0));
    tbl.push_back(mk(0, 0, 1, 32'h003010B3, 0, 5'd0,  32'h0,  1, 0, 7'h33, 3'd1, 7'h00, 5'd1, 32'h0,         32'd0, 32'd0));

    foreach (tbl[i]) apply(tbl[i], tbl[i].exp);

    // randomized traffic, starting from a modelled reset
    t = mk(1, 0, 0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 7'd0, 3'd0, 7'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    model_step(t);
    apply(t, m_out);
    for (int n = 0; n < 3000; n++) begin
      r = $urandom();
      t.rst   = ($urandom_range(0, 63) == 0);
      t.stall = ($urandom_range(0, 3) == 0);
      t.vld   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) t.instr = {r[31:7], r[6:0]};
      else t.instr = {r[31:7], legal_ops[$urandom_range(0, 9)]};
      t.wb_en   = ($urandom_range(0, 1) == 1);
      t.wb_rd   = ($urandom_range(0, 2) == 0) ? t.instr[19:15]
                : ($urandom_range(0, 1) == 0) ? t.instr[24:20] : 5'($urandom_range(0, 31));
      t.wb_data = $urandom();
      model_step(t);
      apply(t, m_out);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (32-bit data, 5-bit register index, 32 registers).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 I_instr_valid  input  1  I_instr carries an instruction this cycle.
REQ-005 I_instr  input  32  RV32I instruction word.
REQ-006 I_stall  input  1  downstream ALU cannot accept; hold outputs.
REQ-007 I_wb_en  input  1  write-back strobe.
REQ-008 I_wb_rd  input  5  write-back destination register.
REQ-009 I_wb_data  input  32  write-back data.
REQ-010 O_ready  output  1  instruction accepted this cycle; equals !I_stall && !rst, combinational.
REQ-011 O_en  output  1  registered valid to the ALU enable input.
REQ-012 O_op  output  7  registered instr[6:0].
REQ-013 O_funct3  output  3  registered instr[14:12].
REQ-014 O_funct7  output  7  registered instr[31:25].
REQ-015 O_dataA  output  32  registered rs1 value.
REQ-016 O_dataB  output  32  registered rs2 value.
REQ-017 O_imm  output  32  registered sign-extended immediate.
REQ-018 O_rd  output  5  registered instr[11:7].
REQ-019 O_illegal  output  1  registered flag: valid instruction with an unsupported opcode.

Function
REQ-020 The register file SHALL be 32x32; x0 SHALL read 0, and writes to x0 SHALL be ignored.
REQ-021 A write SHALL occur on the rising edge when I_wb_en=1 and rst=0, independent of I_stall.
REQ-022 Bypass: when I_wb_en=1 and I_wb_rd matches rs1 or rs2 (nonzero) in the same cycle, the captured operand SHALL be I_wb_data.
REQ-023 Capture: on each edge with I_stall=0, all O_* registers SHALL load the decode of the current input, giving 1-cycle latency.
REQ-024 Hold: on each edge with I_stall=1, all O_* registers SHALL hold their values, and I_instr is not consumed.
REQ-025 When stalled, operands SHALL NOT be refreshed from write-back; upstream re-presents the instruction after the stall.
REQ-026 Legal opcodes: 0110011 R, 0010011 I, 0000011 I, 1100111 I, 0100011 S, 1100011 B, 0110111 U, 0010111 U, 1101111 J, 1110011 I.
REQ-027 Immediate generation: O_imm SHALL be sign-extended from instr[31].
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- R: 0.
REQ-028 O_en SHALL be I_instr_valid && legal opcode at capture.
REQ-029 O_illegal SHALL be I_instr_valid && !legal at capture.
REQ-030 When I_instr_valid=0 at capture, O_en and O_illegal SHALL be 0 and the other O_* fields SHALL be don't-care (implemented as captured decode).
REQ-031 O_en and O_illegal SHALL never both be 1.

Reset
REQ-032 When rst=1 at an edge, all O_* registers and all 32 registers SHALL be set to 0.
REQ-033 Write-back during reset SHALL be ignored.
REQ-034 Reset SHALL take priority over I_stall.
REQ-035 Reset mid-stall SHALL discard the held instruction.
REQ-036 The first capture SHALL occur on the first edge with rst=0 and I_stall=0.

Verification
REQ-037 Reset then decode: rst 1 cycle, then I_instr=0x003010B3 (sll x1,x0,x3) valid -> O_en=0, all outputs 0 after reset; then O_op=0110011, O_funct3=001, O_dataA=0, O_dataB=0, O_rd=1.
REQ-038 Write-back then read: write x3=3, then I_instr=0x003010B3 -> O_dataB=3, O_imm=0, O_en=1 one cycle later.
REQ-039 Same-cycle bypass: I_wb_en=1, I_wb_rd=9, I_wb_data=9 together with I_instr=0x00948163 (beq x9,x9,+2) -> O_dataA=O_dataB=9, O_imm=0x00000002, O_funct3=000.
REQ-040 Immediates: 0x0BA08113 (addi x2,x1,0xBA) -> O_imm=0x000000BA, O_rd=2; 0xFFF00093 (addi x1,x0,-1) -> O_imm=0xFFFFFFFF.
REQ-041 Stall hold: decode 0x0BA08113, then I_stall=1 for 3 cycles while presenting 0xFFF00093 -> O_ready=0 and outputs hold the addi x2 values; first edge after release -> O_imm=0xFFFFFFFF.
REQ-042 Illegal and x0: 0x0000007F valid -> O_en=0, O_illegal=1; write x0=0x55 then read x0 -> 0.
